// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode.
// Holds the PC, issues one outstanding word fetch at a time, buffers returned
// instructions in a small FIFO and hands them to decode over valid/ready.
// A branch redirect flushes buffered and in-flight instructions.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   imem_req, imem_addr         fetch request pulse and address (combinational)
//   imem_rvalid, imem_rdata     memory response strobe and instruction word
//   redirect, redirect_pc       branch redirect and new fetch PC (bits [1:0] ignored)
//   instr_valid, instr,         FIFO head presented to decode
//   instr_pc, instr_ready
//   perf_fetched, perf_flushed  saturating counters, only with FETCH_PERF_CNT_EN
//
// Optional feature macro: FETCH_PERF_CNT_EN
module fetch_unit #(
    parameter int unsigned      PC_W       = 64,
    parameter int unsigned      INSTR_W    = 32,
    parameter int unsigned      FIFO_DEPTH = 2,
    parameter logic [PC_W-1:0]  RESET_PC   = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               instr_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    req_pc_q, req_pc_d;
    logic [CNT_W-1:0]   count_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PC_W-1:0]    fifo_pc_q    [FIFO_DEPTH];
    logic [INSTR_W-1:0] fifo_instr_q [FIFO_DEPTH];

    logic req_c, push_c, pop_c, flush_c;

    // Next-state and request logic
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        req_c    = 1'b0;
        push_c   = 1'b0;
        flush_c  = 1'b0;
        pop_c    = instr_valid && instr_ready;

        case (state_q)
            S_IDLE: begin
                if (!redirect && !reset && (count_q < CNT_W'(FIFO_DEPTH)))
                    req_c = 1'b1;
            end
            S_WAIT: begin
                if (redirect) begin
                    // A response arriving with the redirect is simply discarded
                    state_d = imem_rvalid ? S_IDLE : S_DROP;
                end else if (imem_rvalid) begin
                    push_c = 1'b1;
                    // The word being pushed still occupies a slot next cycle
                    if ((count_q + CNT_W'(1)) < CNT_W'(FIFO_DEPTH))
                        req_c = 1'b1;
                    else
                        state_d = S_IDLE;
                end
            end
            S_DROP: begin
                // The stale response is consumed whether or not a new redirect arrives
                if (imem_rvalid)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect) begin
            flush_c = 1'b1;
            pc_d    = redirect_pc & ~PC_W'(3);
        end

        if (req_c) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_W'(4);
            state_d  = S_WAIT;
        end
    end

    assign imem_req  = req_c;
    assign imem_addr = req_c ? pc_q : '0;

    // FSM and PC registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    // Instruction buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else if (flush_c) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_c) begin
                fifo_pc_q[wr_ptr_q]    <= req_pc_q;
                fifo_instr_q[wr_ptr_q] <= imem_rdata;
                wr_ptr_q               <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign instr_valid = (count_q != '0);
    assign instr       = fifo_instr_q[rd_ptr_q];
    assign instr_pc    = fifo_pc_q[rd_ptr_q];

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        push_c |-> (count_q < CNT_W'(FIFO_DEPTH)));

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] flush_cnt_c;
    logic [32:0]      flushed_sum_c;

    // Entries lost on redirect: what remains after a same-cycle pop plus any in-flight word
    always_comb begin
        flush_cnt_c   = count_q - CNT_W'(pop_c) + CNT_W'(state_q == S_WAIT);
        flushed_sum_c = {1'b0, perf_flushed} + 33'(flush_cnt_c);
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (pop_c && (perf_fetched != 32'hFFFF_FFFF))
                perf_fetched <= perf_fetched + 32'd1;
            if (flush_c)
                perf_flushed <= flushed_sum_c[32] ? 32'hFFFF_FFFF : flushed_sum_c[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a variable-latency memory
// model returning addr>>2 as the instruction word.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = '0;
    logic        redirect;
    logic [63:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready;

    int n_chk  = 0;
    int n_pass = 0;
    int mem_lat = 1;

    logic        pend = 1'b0;
    logic [63:0] pend_addr = '0;
    int          lat_left = 0;

    logic [95:0] mon_q[$];

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    // Memory: response strobe for one cycle, mem_lat cycles after the request
    always begin
        @(negedge clk);
        imem_rvalid = 1'b0;
        if (pend) begin
            lat_left = lat_left - 1;
            if (lat_left == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'(pend_addr >> 2);
                pend        = 1'b0;
            end
        end
        #1;
        if (imem_req) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            lat_left  = mem_lat;
        end
    end

    // Record every instruction handed to decode
    always begin
        @(negedge clk);
        #4;
        if (!reset && instr_valid && instr_ready)
            mon_q.push_back({instr_pc, instr});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic chk_del(input string tag, input int idx, input logic [63:0] pc,
                           input logic [31:0] ins);
        logic [95:0] e;
        e = (idx < mon_q.size()) ? mon_q[idx] : '1;
        chk({tag, "_pc"}, e[95:32], pc);
        chk({tag, "_instr"}, 64'(e[31:0]), 64'(ins));
    endtask

    // Leaves the bench at the negedge of cycle 0 with reset released
    task automatic do_reset(input int lat);
        reset       = 1'b1;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        mem_lat     = lat;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        mon_q.delete();
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        chk("rst_req",   64'(imem_req), 64'd0);
        chk("rst_addr",  imem_addr, 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_pc",    instr_pc, 64'd0);

        // Straight-line fetch
        do_reset(1);
        instr_ready = 1'b1;
        #3;
        chk("sl_c0_req",  64'(imem_req), 64'd1);
        chk("sl_c0_addr", imem_addr, 64'd0);
        @(negedge clk); #3;
        chk("sl_c1_valid", 64'(instr_valid), 64'd0);
        @(negedge clk); #3;
        chk("sl_c2_valid", 64'(instr_valid), 64'd1);
        chk("sl_c2_pc",    instr_pc, 64'd0);
        repeat (12) @(negedge clk);
        for (int i = 0; i < 6; i++)
            chk_del($sformatf("sl_d%0d", i), i, 64'(4 * i), 32'(i));

        // Backpressure
        do_reset(1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #3;
            chk($sformatf("bp_req%0d", i),   64'(imem_req), 64'd0);
            chk($sformatf("bp_valid%0d", i), 64'(instr_valid), 64'd1);
            chk($sformatf("bp_pc%0d", i),    instr_pc, 64'd0);
            @(negedge clk);
        end
        instr_ready = 1'b1;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++)
            chk_del($sformatf("bp_d%0d", i), i, 64'(4 * i), 32'(i));

        // Redirect with a request in flight
        do_reset(2);
        instr_ready = 1'b1;
        #3;
        chk("rf_c0_req", 64'(imem_req), 64'd1);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 64'h103;
        #3;
        chk("rf_c1_req", 64'(imem_req), 64'd0);
        @(negedge clk);
        redirect = 1'b0;
        #3;
        chk("rf_drop_req", 64'(imem_req), 64'd0);
        @(negedge clk); #3;
        chk("rf_c3_req",  64'(imem_req), 64'd1);
        chk("rf_c3_addr", imem_addr, 64'h100);
        repeat (10) @(negedge clk);
        chk_del("rf_d0", 0, 64'h100, 32'h40);
        chk_del("rf_d1", 1, 64'h104, 32'h41);

        // Redirect coincident with response and pop
        do_reset(1);
        instr_ready = 1'b1;
        repeat (5) @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 64'h200;
        #3;
        chk("rc_rvalid", 64'(imem_rvalid), 64'd1);
        chk("rc_valid",  64'(instr_valid), 64'd1);
        chk("rc_pc",     instr_pc, 64'd8);
        chk("rc_req",    64'(imem_req), 64'd0);
        @(negedge clk);
        redirect = 1'b0;
        #3;
        chk("rc_empty",    64'(instr_valid), 64'd0);
        chk("rc_next_req", 64'(imem_req), 64'd1);
        chk("rc_next_addr", imem_addr, 64'h200);
        repeat (8) @(negedge clk);
        chk_del("rc_d2", 2, 64'd8, 32'd2);
        chk_del("rc_d3", 3, 64'h200, 32'h80);

        // PC wrap
        do_reset(1);
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        #3;
        chk("wr_c0_req", 64'(imem_req), 64'd0);
        @(negedge clk);
        redirect = 1'b0;
        #3;
        chk("wr_c1_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        repeat (8) @(negedge clk);
        chk_del("wr_d0", 0, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFF);
        chk_del("wr_d1", 1, 64'd0, 32'd0);
        chk_del("wr_d2", 2, 64'd4, 32'd1);

        // Asynchronous reset mid-WAIT, 3-cycle memory
        do_reset(3);
        repeat (5) @(negedge clk);
        #1;
        chk("ar_pre_valid", 64'(instr_valid), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_valid", 64'(instr_valid), 64'd0);
        chk("ar_pc",    instr_pc, 64'd0);
        chk("ar_instr", 64'(instr), 64'd0);
        chk("ar_req",   64'(imem_req), 64'd0);
        @(negedge clk);
        reset       = 1'b0;
        instr_ready = 1'b1;
        #3;
        chk("ar_stale_rvalid", 64'(imem_rvalid), 64'd1);
        chk("ar_c0_req",  64'(imem_req), 64'd1);
        chk("ar_c0_addr", imem_addr, 64'd0);
        @(negedge clk); #3;
        chk("ar_c1_valid", 64'(instr_valid), 64'd0);
        repeat (10) @(negedge clk);
        chk_del("ar_d0", 0, 64'd0, 32'd0);
        chk_del("ar_d1", 1, 64'd4, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
